// File: rtl/keypad_debounce_fifo.sv
// Debounces the 16-bit keypad bitmap on a slow sample tick, emits one-cycle press
// pulses and queues the pressed key indices in a small show-ahead FIFO.
module keypad_debounce_fifo #(
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 raw,
  output logic [15:0]                 stable,
  output logic [15:0]                 press_pulse,
  output logic                        key_valid,
  output logic [3:0]                  key_code,
  input  logic                        key_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        clr_overflow
);
  localparam int CNT_W = $clog2(STABLE_CNT) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

  logic [15:0]      sync1_q, sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_s;
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];
  logic [15:0]      stable_q, stable_d, pulse_q, pulse_d;
  logic [15:0]      pending_q, pending_d, grant_s;
  logic             push_s;
  logic [3:0]       push_code_s;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pop_s, full_s, wr_en_s, drop_s;

  // Prescaler and per-key debounce: a new level needs STABLE_CNT differing ticks in a row.
  always_comb begin
    tick_s   = (div_q == DIV_LAST);
    div_d    = tick_s ? {DIV_W{1'b0}} : div_q + 1'b1;
    stable_d = stable_q;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!tick_s) begin
        cnt_d[i] = cnt_q[i];
      end else if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    pulse_d = stable_d & ~stable_q;
  end

  // Lowest pending key wins the single push slot each cycle.
  always_comb begin
    grant_s     = pending_q & (~pending_q + 16'h0001);
    pending_d   = (pending_q & ~grant_s) | pulse_q;
    push_s      = |pending_q;
    push_code_s = 4'h0;
    for (int i = 0; i < 16; i++) begin
      push_code_s = push_code_s | (4'(i) & {4{grant_s[i]}});
    end
  end

  always_comb begin
    pop_s    = (count_q != {CW{1'b0}}) & key_ready;
    full_s   = (count_q == DEPTH_C);
    wr_en_s  = push_s & (~full_s | pop_s);
    drop_s   = push_s & full_s & ~pop_s;
    wr_ptr_d = wr_en_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear must still leave the flag set.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 16'h0000;
      sync_q    <= 16'h0000;
      div_q     <= {DIV_W{1'b0}};
      stable_q  <= 16'h0000;
      pulse_q   <= 16'h0000;
      pending_q <= 16'h0000;
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      ovf_q     <= 1'b0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= {CNT_W{1'b0}};
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= 4'h0;
    end else begin
      sync1_q   <= raw;
      sync_q    <= sync1_q;
      div_q     <= div_d;
      stable_q  <= stable_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= push_code_s;
      end
    end
  end

  assign stable      = stable_q;
  assign press_pulse = pulse_q;
  assign key_valid   = (count_q != {CW{1'b0}});
  assign key_code    = mem_q[rd_ptr_q];
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_debounce_fifo.sv
// Directed bench for keypad_debounce_fifo with TICK_DIV=4, STABLE_CNT=3, FIFO_DEPTH=4.
module tb_keypad_debounce_fifo;
  logic        clk = 1'b0;
  logic        rst_n, key_ready, clr_overflow;
  logic [15:0] raw, stable, press_pulse;
  logic        key_valid, overflow;
  logic [3:0]  key_code;
  logic [2:0]  fifo_count;
  int          tests = 0, fails = 0, cyc = 0, pulse_cnt = 0, snap;
  logic [0:5]  tog;

  typedef struct {
    logic [15:0] press;
    logic [3:0]  code;
    logic [2:0]  count;
  } vec_t;
  vec_t vecs [5];

  keypad_debounce_fifo #(.TICK_DIV(4), .STABLE_CNT(3), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .raw(raw), .stable(stable), .press_pulse(press_pulse),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow));

  always #5 clk = ~clk;

  // Bench-side cycle count since reset release; ticks land on edges where cyc % 4 == 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) if (press_pulse != 16'h0000) pulse_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(negedge clk); while (cyc % 4 != 0);
    end
  endtask

  task automatic set_raw(input logic [15:0] v);
    wait_ticks(1);
    raw = v;
  endtask

  task automatic pop_chk(input string name, input logic [3:0] exp);
    chk({name, "_valid"}, {31'd0, key_valid}, 32'd1);
    chk(name, {28'd0, key_code}, {28'd0, exp});
    key_ready = 1'b1;
    clk_n(1);
    key_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0001, 4'd0,  3'd1};
    vecs[1] = '{16'h0080, 4'd7,  3'd1};
    vecs[2] = '{16'h8000, 4'd15, 3'd1};
    vecs[3] = '{16'h4400, 4'd10, 3'd2};
    vecs[4] = '{16'h8421, 4'd0,  3'd4};
    tog = 6'b110110;

    rst_n = 1'b0; raw = 16'h0000; key_ready = 1'b0; clr_overflow = 1'b0;
    clk_n(3);
    chk("rst_stable", {16'd0, stable}, 32'h0);
    chk("rst_pulse", {16'd0, press_pulse}, 32'h0);
    chk("rst_valid", {31'd0, key_valid}, 32'h0);
    chk("rst_count", {29'd0, fifo_count}, 32'h0);
    chk("rst_ovf", {31'd0, overflow}, 32'h0);

    // Clean press of key 5: accepted on the third tick after sync sees it.
    raw = 16'h0020; rst_n = 1'b1;
    wait_ticks(2);
    chk("k5_stable_early", {16'd0, stable}, 32'h0);
    wait_ticks(1);
    chk("k5_stable", {16'd0, stable}, 32'h20);
    chk("k5_pulse", {16'd0, press_pulse}, 32'h20);
    clk_n(1);
    chk("k5_pulse_one", {16'd0, press_pulse}, 32'h0);
    chk("k5_valid_early", {31'd0, key_valid}, 32'h0);
    clk_n(1);
    chk("k5_count", {29'd0, fifo_count}, 32'h1);
    pop_chk("k5_code", 4'd5);
    chk("k5_valid_after_pop", {31'd0, key_valid}, 32'h0);
    chk("k5_count_after_pop", {29'd0, fifo_count}, 32'h0);

    // Bouncing key 2 never reaches three agreeing ticks.
    wait_ticks(1);
    snap = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      raw = tog[i] ? 16'h0024 : 16'h0020;
      wait_ticks(1);
      chk("bounce_stable", {16'd0, stable}, 32'h20);
    end
    chk("bounce_no_pulse", pulse_cnt, snap);
    chk("bounce_count", {29'd0, fifo_count}, 32'h0);
    raw = 16'h0024;
    wait_ticks(3);
    chk("k2_pulse", {16'd0, press_pulse}, 32'h4);
    clk_n(2);
    pop_chk("k2_code", 4'd2);
    set_raw(16'h0020);
    wait_ticks(3);
    chk("k2_release", {16'd0, stable}, 32'h20);

    // Two simultaneous presses are queued in ascending order.
    set_raw(16'h0228);
    wait_ticks(3);
    chk("dual_pulse", {16'd0, press_pulse}, 32'h208);
    clk_n(2);
    chk("dual_count1", {29'd0, fifo_count}, 32'h1);
    clk_n(1);
    chk("dual_count2", {29'd0, fifo_count}, 32'h2);
    pop_chk("dual_first", 4'd3);
    pop_chk("dual_second", 4'd9);
    chk("dual_empty", {29'd0, fifo_count}, 32'h0);
    set_raw(16'h0020);
    wait_ticks(3);
    chk("dual_release", {16'd0, stable}, 32'h20);

    // Five presses into a 4-deep FIFO: code 4 is dropped.
    set_raw(16'h003F);
    wait_ticks(3);
    chk("ovf_pulse", {16'd0, press_pulse}, 32'h1F);
    clk_n(5);
    chk("ovf_full", {29'd0, fifo_count}, 32'h4);
    chk("ovf_not_yet", {31'd0, overflow}, 32'h0);
    clk_n(1);
    chk("ovf_count", {29'd0, fifo_count}, 32'h4);
    chk("ovf_set", {31'd0, overflow}, 32'h1);
    for (int i = 0; i < 4; i++) pop_chk("ovf_pop", 4'(i));
    chk("ovf_drained", {29'd0, fifo_count}, 32'h0);
    chk("ovf_sticky", {31'd0, overflow}, 32'h1);
    clr_overflow = 1'b1;
    clk_n(1);
    clr_overflow = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'h0);

    // Push and pop in the same cycle while full.
    set_raw(16'h0020);
    wait_ticks(3);
    set_raw(16'h002F);
    wait_ticks(3);
    clk_n(6);
    chk("full_count", {29'd0, fifo_count}, 32'h4);
    set_raw(16'h006F);
    wait_ticks(3);
    chk("full_pulse", {16'd0, press_pulse}, 32'h40);
    clk_n(1);
    key_ready = 1'b1;
    clk_n(1);
    key_ready = 1'b0;
    chk("full_pushpop_count", {29'd0, fifo_count}, 32'h4);
    chk("full_pushpop_ovf", {31'd0, overflow}, 32'h0);
    pop_chk("full_pop1", 4'd1);
    pop_chk("full_pop2", 4'd2);
    pop_chk("full_pop3", 4'd3);
    pop_chk("full_pop6", 4'd6);
    chk("full_empty", {29'd0, fifo_count}, 32'h0);

    // Releasing every key: level falls on the third tick, no pulse or code.
    set_raw(16'h0000);
    snap = pulse_cnt;
    wait_ticks(2);
    chk("rel_hold", {16'd0, stable}, 32'h6F);
    wait_ticks(1);
    chk("rel_fall", {16'd0, stable}, 32'h0);
    clk_n(4);
    chk("rel_no_pulse", pulse_cnt, snap);
    chk("rel_no_code", {29'd0, fifo_count}, 32'h0);

    for (int v = 0; v < 5; v++) begin
      set_raw(vecs[v].press);
      wait_ticks(3);
      chk("vec_pulse", {16'd0, press_pulse}, {16'd0, vecs[v].press});
      clk_n(8);
      chk("vec_stable", {16'd0, stable}, {16'd0, vecs[v].press});
      chk("vec_count", {29'd0, fifo_count}, {29'd0, vecs[v].count});
      chk("vec_code", {28'd0, key_code}, {28'd0, vecs[v].code});
      chk("vec_ovf", {31'd0, overflow}, 32'h0);
      key_ready = 1'b1;
      clk_n(int'(vecs[v].count));
      key_ready = 1'b0;
      chk("vec_drained", {29'd0, fifo_count}, 32'h0);
      set_raw(16'h0000);
      wait_ticks(3);
      chk("vec_release", {16'd0, stable}, 32'h0);
    end

    // Asynchronous reset mid-debounce with two codes queued.
    set_raw(16'h0180);
    wait_ticks(3);
    clk_n(3);
    chk("arst_queued", {29'd0, fifo_count}, 32'h2);
    raw = 16'h0000;
    wait_ticks(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stable", {16'd0, stable}, 32'h0);
    chk("arst_pulse", {16'd0, press_pulse}, 32'h0);
    chk("arst_valid", {31'd0, key_valid}, 32'h0);
    chk("arst_code", {28'd0, key_code}, 32'h0);
    chk("arst_count", {29'd0, fifo_count}, 32'h0);
    chk("arst_ovf", {31'd0, overflow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    snap = pulse_cnt;
    clk_n(24);
    chk("post_rst_valid", {31'd0, key_valid}, 32'h0);
    chk("post_rst_count", {29'd0, fifo_count}, 32'h0);
    chk("post_rst_stable", {16'd0, stable}, 32'h0);
    chk("post_rst_pulse", pulse_cnt, snap);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
